// File: rtl/qspi_req_arb.sv
// Purpose : arbitrates CPU fetch and data ports onto the single QSPI controller request interface,
//           one transaction in flight, with a completion watchdog.
// Backpres: requests arriving while their port is busy are dropped; the caller must watch *_busy.
//
// Latency : request pulse -> read_req/write_req two edges later; completion -> response one edge later.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req/i_adr                   fetch request pulse and byte address
//   i_busy/i_valid/i_rdata        fetch pending-or-in-flight, data valid pulse, data
//   d_rd_req/d_wr_req             data read / write request pulses (write wins if both)
//   d_w/d_hw/d_adr/d_wdata        data size (word, halfword, else byte), address, write data
//   d_busy/d_rvalid/d_rdata       data pending-or-in-flight, read valid pulse, read data
//   d_wdone                       write complete pulse
//   to_err                        watchdog abort pulse, coincident with the owner's response
//   read_* / write_*              request side of the QSPI controller
//   read_valid/read_data          read completion from controller
//   write_finish                  write completion from controller
module qspi_req_arb #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_adr,
    output logic        i_busy,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_rd_req,
    input  logic        d_wr_req,
    input  logic        d_w,
    input  logic        d_hw,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    output logic        d_busy,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_wdone,
    output logic        to_err,
    output logic        read_req,
    output logic        read_w,
    output logic        read_hw,
    output logic [31:0] read_adr,
    input  logic        read_valid,
    input  logic [31:0] read_data,
    output logic        write_req,
    output logic        write_w,
    output logic        write_hw,
    output logic [31:0] write_adr,
    output logic [31:0] write_data,
    input  logic        write_finish
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD_I = 2'd1;
    localparam logic [1:0] ST_RD_D = 2'd2;
    localparam logic [1:0] ST_WR_D = 2'd3;

    // Watchdog fires on the cycle the timer holds TIMEOUT_CYC-1; zero disables it.
    localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef struct packed {
        logic        wr;
        logic        w;
        logic        hw;
        logic [31:0] adr;
        logic [31:0] wdata;
    } dreq_t;

    logic [1:0]  state;
    logic        i_pend_vld;
    logic [31:0] i_pend_adr;
    logic        d_pend_vld;
    dreq_t       d_pend;
    logic        last_grant_d;   // 1: data port won the most recent tie
    logic [15:0] timer;

    logic rd_done;
    logic wr_done;
    logic to_hit;
    logic grant_d;
    logic grant_i;

    assign i_busy = i_pend_vld | (state == ST_RD_I);
    assign d_busy = d_pend_vld | (state == ST_RD_D) | (state == ST_WR_D);

    // Completions are only honoured in the matching state; strays are ignored.
    assign rd_done = read_valid & ((state == ST_RD_I) | (state == ST_RD_D));
    assign wr_done = write_finish & (state == ST_WR_D);
    // A completion on the expiry cycle takes precedence over the abort.
    assign to_hit  = TO_EN & (state != ST_IDLE) & (timer == TO_LAST) & ~rd_done & ~wr_done;

    // Single pending port wins outright; on a tie the port that lost last tie goes.
    assign grant_d = (state == ST_IDLE) & d_pend_vld & (~i_pend_vld | ~last_grant_d);
    assign grant_i = (state == ST_IDLE) & i_pend_vld & ~grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            i_pend_vld   <= 1'b0;
            i_pend_adr   <= '0;
            d_pend_vld   <= 1'b0;
            d_pend       <= '0;
            last_grant_d <= 1'b0;
            timer        <= '0;
            i_valid      <= 1'b0;
            i_rdata      <= '0;
            d_rvalid     <= 1'b0;
            d_rdata      <= '0;
            d_wdone      <= 1'b0;
            to_err       <= 1'b0;
            read_req     <= 1'b0;
            read_w       <= 1'b0;
            read_hw      <= 1'b0;
            read_adr     <= '0;
            write_req    <= 1'b0;
            write_w      <= 1'b0;
            write_hw     <= 1'b0;
            write_adr    <= '0;
            write_data   <= '0;
        end else begin
            read_req  <= 1'b0;
            write_req <= 1'b0;
            i_valid   <= 1'b0;
            d_rvalid  <= 1'b0;
            d_wdone   <= 1'b0;
            to_err    <= 1'b0;

            // Capture never collides with a grant: a grant needs the pending
            // flag set, which already holds busy high and blocks capture.
            if (i_req && !i_busy) begin
                i_pend_vld <= 1'b1;
                i_pend_adr <= i_adr;
            end
            if ((d_rd_req || d_wr_req) && !d_busy) begin
                d_pend_vld   <= 1'b1;
                d_pend.wr    <= d_wr_req;
                d_pend.w     <= d_w;
                d_pend.hw    <= d_hw;
                d_pend.adr   <= d_adr;
                d_pend.wdata <= d_wdata;
            end

            if (state == ST_IDLE) begin
                if (grant_d) begin
                    d_pend_vld <= 1'b0;
                    timer      <= '0;
                    if (i_pend_vld) begin
                        last_grant_d <= 1'b1;
                    end
                    if (d_pend.wr) begin
                        state      <= ST_WR_D;
                        write_req  <= 1'b1;
                        write_w    <= d_pend.w;
                        write_hw   <= d_pend.hw;
                        write_adr  <= d_pend.adr;
                        write_data <= d_pend.wdata;
                    end else begin
                        state    <= ST_RD_D;
                        read_req <= 1'b1;
                        read_w   <= d_pend.w;
                        read_hw  <= d_pend.hw;
                        read_adr <= d_pend.adr;
                    end
                end else if (grant_i) begin
                    i_pend_vld <= 1'b0;
                    timer      <= '0;
                    if (d_pend_vld) begin
                        last_grant_d <= 1'b0;
                    end
                    state    <= ST_RD_I;
                    read_req <= 1'b1;
                    read_w   <= 1'b1;
                    read_hw  <= 1'b0;
                    read_adr <= i_pend_adr;
                end
            end else begin
                timer <= timer + 16'd1;
                if (rd_done || wr_done || to_hit) begin
                    state  <= ST_IDLE;
                    to_err <= to_hit;
                    case (state)
                        ST_RD_I: begin
                            i_valid <= 1'b1;
                            i_rdata <= rd_done ? read_data : 32'd0;
                        end
                        ST_RD_D: begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= rd_done ? read_data : 32'd0;
                        end
                        default: begin
                            d_wdone <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_qspi_req_arb.sv
// Purpose : self-checking bench for qspi_req_arb acting as CPU ports and QSPI controller.
// Latency : checks issue two edges after a request and response one edge after completion.
// Backpres: exercises request drops while busy and watchdog aborts.
module tb_qspi_req_arb;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_adr;
    logic        i_busy;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_rd_req;
    logic        d_wr_req;
    logic        d_w;
    logic        d_hw;
    logic [31:0] d_adr;
    logic [31:0] d_wdata;
    logic        d_busy;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_wdone;
    logic        to_err;
    logic        read_req;
    logic        read_w;
    logic        read_hw;
    logic [31:0] read_adr;
    logic        read_valid;
    logic [31:0] read_data;
    logic        write_req;
    logic        write_w;
    logic        write_hw;
    logic [31:0] write_adr;
    logic [31:0] write_data;
    logic        write_finish;

    qspi_req_arb #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_adr(i_adr), .i_busy(i_busy), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_w(d_w), .d_hw(d_hw), .d_adr(d_adr),
        .d_wdata(d_wdata), .d_busy(d_busy), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_wdone(d_wdone), .to_err(to_err),
        .read_req(read_req), .read_w(read_w), .read_hw(read_hw), .read_adr(read_adr),
        .read_valid(read_valid), .read_data(read_data),
        .write_req(write_req), .write_w(write_w), .write_hw(write_hw), .write_adr(write_adr),
        .write_data(write_data), .write_finish(write_finish)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit last_d;   // model: 1 when the data port won the most recent tie

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample point is 1 time unit after the edge. Pulses last one cycle.
    task automatic step();
        @(posedge clk);
        #1;
        i_req        = 1'b0;
        d_rd_req     = 1'b0;
        d_wr_req     = 1'b0;
        read_valid   = 1'b0;
        write_finish = 1'b0;
    endtask

    function automatic logic done_of(input bit own_d, input bit wr);
        return own_d ? (wr ? d_wdone : d_rvalid) : i_valid;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_i_busy"}, i_busy, 1'b0);
        chk1({tag, "_i_valid"}, i_valid, 1'b0);
        chk32({tag, "_i_rdata"}, i_rdata, 32'd0);
        chk1({tag, "_d_busy"}, d_busy, 1'b0);
        chk1({tag, "_d_rvalid"}, d_rvalid, 1'b0);
        chk32({tag, "_d_rdata"}, d_rdata, 32'd0);
        chk1({tag, "_d_wdone"}, d_wdone, 1'b0);
        chk1({tag, "_to_err"}, to_err, 1'b0);
        chk1({tag, "_read_req"}, read_req, 1'b0);
        chk1({tag, "_read_w"}, read_w, 1'b0);
        chk1({tag, "_read_hw"}, read_hw, 1'b0);
        chk32({tag, "_read_adr"}, read_adr, 32'd0);
        chk1({tag, "_write_req"}, write_req, 1'b0);
        chk1({tag, "_write_w"}, write_w, 1'b0);
        chk1({tag, "_write_hw"}, write_hw, 1'b0);
        chk32({tag, "_write_adr"}, write_adr, 32'd0);
        chk32({tag, "_write_data"}, write_data, 32'd0);
    endtask

    // Nothing issued and nothing busy for a few cycles.
    task automatic quiet();
        for (int q = 0; q < 3; q++) begin
            step();
            chk1("quiet_req", read_req | write_req, 1'b0);
            chk1("quiet_busy", i_busy | d_busy, 1'b0);
            chk1("quiet_resp", i_valid | d_rvalid | d_wdone | to_err, 1'b0);
        end
    endtask

    // Act as the controller for one expected transaction. The controller answers
    // lat cycles after the issue cycle; anything later than TO-1 is a watchdog abort
    // answered at issue+TO with zero data, and the late completion must be ignored.
    task automatic serve(input bit own_d, input bit exp_wr, input logic [31:0] exp_adr,
                         input bit exp_w, input bit exp_hw, input logic [31:0] exp_wd,
                         input int lat, input logic [31:0] rsp, input int exp_wait,
                         input bit drop);
        int          waited = 0;
        int          resp_k;
        int          k_end;
        bit          tout;
        logic [31:0] exp_rd;
        while (read_req !== 1'b1 && write_req !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        chk1("issue_seen", read_req | write_req, 1'b1);
        if (read_req !== 1'b1 && write_req !== 1'b1) return;
        if (exp_wait >= 0) chk32("issue_latency", 32'(waited), 32'(exp_wait));
        chk1("issue_kind", write_req, exp_wr);
        chk1("issue_single", read_req & write_req, 1'b0);
        if (exp_wr) begin
            chk32("write_adr", write_adr, exp_adr);
            chk1("write_w", write_w, exp_w);
            chk1("write_hw", write_hw, exp_hw);
            chk32("write_data", write_data, exp_wd);
        end else begin
            chk32("read_adr", read_adr, exp_adr);
            chk1("read_w", read_w, exp_w);
            chk1("read_hw", read_hw, exp_hw);
        end
        tout   = (lat > TO - 1);
        resp_k = tout ? TO : lat + 1;
        k_end  = (lat + 1 > resp_k + 1) ? lat + 1 : resp_k + 1;
        exp_rd = tout ? 32'd0 : rsp;
        read_data = $urandom;
        if (lat == 0) begin
            if (exp_wr) write_finish = 1'b1;
            else begin read_valid = 1'b1; read_data = rsp; end
        end
        for (int k = 1; k <= k_end; k++) begin
            step();
            if (k == 1) chk1("req_one_shot", read_req | write_req, 1'b0);
            if (k < resp_k) begin
                chk1("busy_in_flight", own_d ? d_busy : i_busy, 1'b1);
                chk1("no_early_done", done_of(own_d, exp_wr), 1'b0);
            end
            if (k == resp_k - 1) chk32("adr_held", exp_wr ? write_adr : read_adr, exp_adr);
            if (k == resp_k) begin
                chk1("done_pulse", done_of(own_d, exp_wr), 1'b1);
                chk1("to_err", to_err, tout);
                chk1("busy_falls", own_d ? d_busy : i_busy, 1'b0);
                if (own_d) chk1("other_quiet", i_valid, 1'b0);
                else       chk1("other_quiet", d_rvalid | d_wdone, 1'b0);
                if (!exp_wr) chk32("rdata", own_d ? d_rdata : i_rdata, exp_rd);
            end
            if (k > resp_k) begin
                chk1("no_extra_done", done_of(own_d, exp_wr), 1'b0);
                chk1("no_extra_to_err", to_err, 1'b0);
            end
            if (k == lat) begin
                if (exp_wr) write_finish = 1'b1;
                else begin read_valid = 1'b1; read_data = rsp; end
            end
            if (k == 1 && drop && lat >= 1) begin
                if (own_d) begin d_rd_req = 1'b1; d_adr = 32'hDEAD_0000; end
                else       begin i_req = 1'b1;    i_adr = 32'hDEAD_0004; end
            end
        end
    endtask

    initial begin
        bit          sel_i;
        bit          sel_d;
        bit          wr;
        bit          d_first;
        int          sz;
        int          li;
        int          ld;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] ri;
        logic [31:0] rd;

        rst = 1'b1; i_req = 1'b0; i_adr = '0; d_rd_req = 1'b0; d_wr_req = 1'b0;
        d_w = 1'b0; d_hw = 1'b0; d_adr = '0; d_wdata = '0;
        read_valid = 1'b0; read_data = '0; write_finish = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // Fetch only, controller answers three cycles after read_req.
        i_adr = 32'h100; i_req = 1'b1;
        step();
        chk1("fetch_busy_rise", i_busy, 1'b1);
        chk1("fetch_d_idle", d_busy, 1'b0);
        serve(1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 32'd0, 3, 32'h1234_5678, 1, 1'b0);
        quiet();

        // Tie after reset: data first, then fetch. Second tie: fetch first.
        i_adr = 32'h200; i_req = 1'b1;
        d_adr = 32'h300; d_wdata = 32'hCAFE_BABE; d_w = 1'b1; d_hw = 1'b0; d_wr_req = 1'b1;
        serve(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'hCAFE_BABE, 2, 32'd0, 2, 1'b0);
        serve(1'b0, 1'b0, 32'h200, 1'b1, 1'b0, 32'd0, 2, 32'h0BAD_F00D, 0, 1'b0);
        quiet();
        i_adr = 32'h204; i_req = 1'b1;
        d_adr = 32'h304; d_wdata = 32'h1122_3344; d_wr_req = 1'b1;
        serve(1'b0, 1'b0, 32'h204, 1'b1, 1'b0, 32'd0, 1, 32'h5566_7788, 2, 1'b0);
        serve(1'b1, 1'b1, 32'h304, 1'b1, 1'b0, 32'h1122_3344, 1, 32'd0, 0, 1'b0);
        quiet();

        // Halfword data read.
        d_adr = 32'h402; d_w = 1'b0; d_hw = 1'b1; d_rd_req = 1'b1;
        serve(1'b1, 1'b0, 32'h402, 1'b0, 1'b1, 32'd0, 2, 32'hA5A5_5A5A, 2, 1'b0);
        quiet();

        // Watchdog: controller answers far too late.
        d_adr = 32'h404; d_w = 1'b1; d_hw = 1'b0; d_rd_req = 1'b1;
        serve(1'b1, 1'b0, 32'h404, 1'b1, 1'b0, 32'd0, 10, 32'hDEAD_BEEF, 2, 1'b0);
        quiet();

        // Reset while a data read is in flight.
        d_adr = 32'h500; d_rd_req = 1'b1;
        step();
        step();
        chk1("rst_mid_issue", read_req, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("rst_mid");
        read_valid = 1'b1; read_data = 32'h7777_7777;
        quiet();
        i_adr = 32'h600; i_req = 1'b1;
        serve(1'b0, 1'b0, 32'h600, 1'b1, 1'b0, 32'd0, 1, 32'h6060_6060, 2, 1'b0);
        quiet();

        // Data request while busy is dropped.
        d_adr = 32'h700; d_rd_req = 1'b1;
        step();
        chk1("drop_busy", d_busy, 1'b1);
        d_adr = 32'h7FC; d_rd_req = 1'b1;
        serve(1'b1, 1'b0, 32'h700, 1'b1, 1'b0, 32'd0, 2, 32'h0700_0700, 1, 1'b0);
        quiet();

        // Randomised rounds against a transaction-level model.
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_d = 1'b0;
        step();
        for (int r = 0; r < 40; r++) begin
            sz    = $urandom_range(0, 2);
            sel_i = 1'b0;
            sel_d = 1'b0;
            case ($urandom_range(0, 2))
                0:       sel_i = 1'b1;
                1:       sel_d = 1'b1;
                default: begin sel_i = 1'b1; sel_d = 1'b1; end
            endcase
            wr  = 1'($urandom_range(0, 1));
            ia  = $urandom;
            da  = $urandom;
            dwd = $urandom;
            ri  = $urandom;
            rd  = $urandom;
            li  = $urandom_range(0, TO);
            ld  = $urandom_range(0, TO);
            if (sel_i) begin i_adr = ia; i_req = 1'b1; end
            if (sel_d) begin
                d_adr = da; d_wdata = dwd; d_w = (sz == 2); d_hw = (sz == 1);
                d_wr_req = wr;
                d_rd_req = !wr || ($urandom_range(0, 3) == 0);
            end
            if (sel_i && sel_d) begin
                d_first = !last_d;
                last_d  = d_first;
            end else begin
                d_first = sel_d;
            end
            if (d_first) begin
                serve(1'b1, wr, da, sz == 2, sz == 1, dwd, ld, rd, 2,
                      1'($urandom_range(0, 1)));
                if (sel_i) serve(1'b0, 1'b0, ia, 1'b1, 1'b0, 32'd0, li, ri, 0,
                                 1'($urandom_range(0, 1)));
            end else begin
                serve(1'b0, 1'b0, ia, 1'b1, 1'b0, 32'd0, li, ri, 2,
                      1'($urandom_range(0, 1)));
                if (sel_d) serve(1'b1, wr, da, sz == 2, sz == 1, dwd, ld, rd, 0,
                                 1'($urandom_range(0, 1)));
            end
            quiet();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
